// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared encodings for the data-memory load/store stage.
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // funct3 width codes; stores reuse the low three load codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Word-oriented data-memory request/acknowledge bus with strobes.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_wstrb;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Byte-lane steering for stores, extraction/extension for loads,
//            and legality checks on the incoming request.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic        req_is_store,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_store_data,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  output logic        req_illegal,
  output logic        req_misaligned,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_load_data
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  always_comb begin
    req_wstrb = 4'b0000;
    req_wdata = req_store_data;
    if (req_is_store) begin
      case (req_funct3)
        F3_SB: begin
          req_wstrb = 4'b0001 << req_offset;
          req_wdata = {4{req_store_data[7:0]}};
        end
        F3_SH: begin
          req_wstrb = 4'b0011 << {req_offset[1], 1'b0};
          req_wdata = {2{req_store_data[15:0]}};
        end
        default: req_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      F3_LBU, F3_LHU:         req_illegal = req_is_store;
      default:                req_illegal = 1'b0;
    endcase
  end

  always_comb begin
    case (req_funct3)
      F3_LH, F3_LHU: req_misaligned = req_offset[0];
      F3_LW:         req_misaligned = (req_offset != 2'b00);
      default:       req_misaligned = 1'b0;
    endcase
  end

  assign rsp_byte = rsp_rdata[{rsp_offset, 3'b000} +: 8];
  assign rsp_half = rsp_rdata[{rsp_offset[1], 4'b0000} +: 16];

  always_comb begin
    case (rsp_funct3)
      F3_LB:   rsp_load_data = {{24{rsp_byte[7]}}, rsp_byte};
      F3_LH:   rsp_load_data = {{16{rsp_half[15]}}, rsp_half};
      F3_LBU:  rsp_load_data = {24'h000000, rsp_byte};
      F3_LHU:  rsp_load_data = {16'h0000, rsp_half};
      default: rsp_load_data = rsp_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multi-cycle data-memory access stage with stall, done and fault.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  fault,
  output logic [1:0]            fault_code,
  load_store_unit_if.master     mem
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [1:0]            offset_q, offset_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  done_q, done_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic        lane_illegal;
  logic        lane_misaligned;
  logic [31:0] lane_load_data;

  lsu_lane_align u_lane_align (
    .req_funct3     (funct3),
    .req_is_store   (req_is_store),
    .req_offset     (addr[1:0]),
    .req_store_data (store_data),
    .req_wstrb      (lane_wstrb),
    .req_wdata      (lane_wdata),
    .req_illegal    (lane_illegal),
    .req_misaligned (lane_misaligned),
    .rsp_funct3     (funct3_q),
    .rsp_offset     (offset_q),
    .rsp_rdata      (mem.mem_rdata),
    .rsp_load_data  (lane_load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    offset_d     = offset_q;
    funct3_d     = funct3_q;
    done_d       = 1'b0;
    load_data_d  = 32'h0;
    fault_d      = 1'b0;
    fault_code_d = FAULT_NONE;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (req_valid) begin
          // Illegal encodings take priority over alignment checks
          if (lane_illegal) begin
            state_d      = ST_ERR;
            fault_d      = 1'b1;
            fault_code_d = FAULT_ILLEGAL;
          end else if (lane_misaligned) begin
            state_d      = ST_ERR;
            fault_d      = 1'b1;
            fault_code_d = FAULT_MISALIGN;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb_d = lane_wstrb;
            mem_wdata_d = lane_wdata;
            offset_d    = addr[1:0];
            funct3_d    = funct3;
          end
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still completes the access
        if (mem.mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          done_d      = 1'b1;
          load_data_d = mem_we_q ? 32'h0 : lane_load_data;
        end else if ((cnt_q + 8'd1) == TIMEOUT_LIMIT) begin
          state_d      = ST_ERR;
          mem_req_d    = 1'b0;
          cnt_d        = 8'd0;
          fault_d      = 1'b1;
          fault_code_d = FAULT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      offset_q     <= 2'b00;
      funct3_q     <= 3'b000;
      done_q       <= 1'b0;
      load_data_q  <= 32'h0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      offset_q     <= offset_d;
      funct3_q     <= funct3_d;
      done_q       <= done_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign stall         = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_REQ);
  assign done          = done_q;
  assign load_data     = load_data_q;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench: vector table plus reset/timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_code;

  load_store_unit_if #(.ADDR_WIDTH(32)) mem_bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES (4),
    .ADDR_WIDTH     (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_is_store (req_is_store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .fault        (fault),
    .fault_code   (fault_code),
    .mem          (mem_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic        exp_fault;
    logic [1:0]  exp_code;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb_q[$];
  vec_t mon_h;
  bit   mem_seen = 1'b0;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int dly,
                              input logic ef, input logic [1:0] ec, input logic [3:0] es,
                              input logic [31:0] ew, input logic [31:0] el);
    vec_t v;
    v.is_store = st;  v.f3 = f3;  v.addr = a;  v.sdata = sd;  v.rdata = rd;
    v.ack_delay = dly; v.exp_fault = ef; v.exp_code = ec; v.exp_strb = es;
    v.exp_wdata = ew; v.exp_load = el;
    return v;
  endfunction

  // Scoreboard monitor: checks the bus on the first request cycle, and the
  // completion against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      mem_seen = 1'b0;
    end else begin
      if (mem_bus.mem_req && !mem_seen) begin
        mem_seen = 1'b1;
        if (sb_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          mon_h = sb_q[0];
          chk("mem_addr", mem_bus.mem_addr, {mon_h.addr[31:2], 2'b00});
          chk("mem_we", {31'd0, mem_bus.mem_we}, {31'd0, mon_h.is_store});
          chk("mem_wstrb", {28'd0, mem_bus.mem_wstrb}, {28'd0, mon_h.exp_strb});
          if (mon_h.is_store) chk("mem_wdata", mem_bus.mem_wdata, mon_h.exp_wdata);
        end
      end
      if (done || fault) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_completion", {30'd0, done, fault}, 32'd0);
        end else begin
          mon_h = sb_q.pop_front();
          mem_seen = 1'b0;
          chk("fault", {31'd0, fault}, {31'd0, mon_h.exp_fault});
          chk("fault_code", {30'd0, fault_code}, {30'd0, mon_h.exp_code});
          if (!mon_h.exp_fault) chk("load_data", load_data, mon_h.exp_load);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = v.is_store; funct3 = v.f3;
    addr = v.addr; store_data = v.sdata;
    sb_q.push_back(v);
    #1 chk("stall_c0", {31'd0, stall}, 32'd1);
    @(negedge clk);
    // Garbage requests while busy must be ignored
    req_valid = 1'b1; funct3 = 3'b111; addr = $urandom; store_data = $urandom;
    if (v.exp_fault) begin
      chk("fault_c1", {31'd0, fault}, 32'd1);
      chk("err_no_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
      chk("stall_err", {31'd0, stall}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
    end else begin
      waited = 0;
      while (waited <= v.ack_delay) begin
        chk("stall_req", {31'd0, stall}, 32'd1);
        chk("mem_req_high", {31'd0, mem_bus.mem_req}, 32'd1);
        if (waited == v.ack_delay) begin
          mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = v.rdata;
        end else begin
          mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom;
        end
        @(negedge clk);
        waited++;
      end
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom; req_valid = 1'b0;
      chk("done_latency", {31'd0, done}, 32'd1);
      chk("mem_req_dropped", {31'd0, mem_bus.mem_req}, 32'd0);
      chk("stall_resp", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_bus.mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'd0, mem_bus.mem_wstrb}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_fault_code"}, {30'd0, fault_code}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 2'b00, 4'b1000, 32'hA5A5A5A5, 32'h0);
    vecs[2]  = mk(0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 2'b00, 4'b0000, 32'h0, 32'hFFFFFF80);
    vecs[3]  = mk(0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1, 0, 2'b00, 4'b0000, 32'h0, 32'h00000080);
    vecs[4]  = mk(0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 0, 2'b00, 4'b0000, 32'h0, 32'hFFFF8001);
    vecs[5]  = mk(0, 3'b101, 32'h102, 32'h0,        32'h80011234, 0, 0, 2'b00, 4'b0000, 32'h0, 32'h00008001);
    vecs[6]  = mk(0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 2'b01, 4'b0000, 32'h0, 32'h0);
    vecs[7]  = mk(0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 2'b10, 4'b0000, 32'h0, 32'h0);
    vecs[8]  = mk(1, 3'b100, 32'h100, 32'h11,       32'h0,        0, 1, 2'b10, 4'b0000, 32'h0, 32'h0);
    vecs[9]  = mk(1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        2, 0, 2'b00, 4'b1100, 32'hABCDABCD, 32'h0);
    vecs[10] = mk(0, 3'b010, 32'h104, 32'h0,        32'h12345678, 3, 0, 2'b00, 4'b0000, 32'h0, 32'h12345678);
    vecs[11] = mk(1, 3'b010, 32'h102, 32'h55,       32'h0,        0, 1, 2'b01, 4'b0000, 32'h0, 32'h0);
    vecs[12] = mk(0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 0, 2'b00, 4'b0000, 32'h0, 32'h0000007F);
    vecs[13] = mk(0, 3'b001, 32'h100, 32'h0,        32'h0000FFFE, 1, 0, 2'b00, 4'b0000, 32'h0, 32'hFFFFFFFE);
    vecs[14] = mk(1, 3'b111, 32'h100, 32'h0,        32'h0,        0, 1, 2'b10, 4'b0000, 32'h0, 32'h0);
    vecs[15] = mk(1, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 2'b01, 4'b0000, 32'h0, 32'h0);
    vecs[16] = mk(1, 3'b000, 32'h100, 32'h11223344, 32'h0,        0, 0, 2'b00, 4'b0001, 32'h44444444, 32'h0);

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Timeout: no ack, request held for exactly TIMEOUT_CYCLES cycles
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
    sb_q.push_back(mk(0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 1, 2'b11, 4'b0000, 32'h0, 32'h0));
    @(negedge clk);
    req_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (fault) break;
      if (mem_bus.mem_req) req_cycles++;
      @(negedge clk);
    end
    chk("timeout_fault_seen", {31'd0, fault}, 32'd1);
    chk("timeout_req_cycles", req_cycles, 32'd4);
    chk("timeout_mem_req_low", {31'd0, mem_bus.mem_req}, 32'd0);
    mem_bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_no_done", {31'd0, done}, 32'd0);
      chk("late_ack_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
    end
    mem_bus.mem_ack = 1'b0;

    // Reset during the third REQ cycle, with an ack in flight
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h300; store_data = 32'hCAFEF00D;
    sb_q.push_back(mk(1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0, 2'b00, 4'b1111, 32'hCAFEF00D, 32'h0));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    sb_q.delete();
    mem_bus.mem_ack = 1'b0;
    chk_all_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    run_vec(mk(1, 3'b010, 32'h104, 32'h0BADF00D, 32'h0, 0, 0, 2'b00, 4'b1111, 32'h0BADF00D, 32'h0));
    @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
